// File: rtl/lane_delay_pkg.sv
// lane_delay_pkg: shared lane state, width helpers and reset constants for lane_delay_line.
package lane_delay_pkg;
    typedef enum logic {LD_SETTLE, LD_LOCKED} ld_state_e;
    localparam ld_state_e LD_RST_STATE = LD_SETTLE;
    localparam logic LD_RST_READY = 1'b0;
    localparam logic LD_RST_ERR = 1'b0;
    function automatic int ptr_w(input int max_delay);
        return max_delay > 1 ? $clog2(max_delay) : 1;
    endfunction
    function automatic int dly_w(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction
    function automatic int ch_w(input int n_ch);
        return n_ch > 1 ? $clog2(n_ch) : 1;
    endfunction
endpackage

// File: rtl/lane_delay_ch.sv
// lane_delay_ch: one lane; sample ring, delayed read, settle FSM and output forcing.
// Optional complementary output dout_n when LANE_DELAY_DIFF_OUT_EN is defined.
module lane_delay_ch
    import lane_delay_pkg::*;
#(
    parameter int DATA_W        = 1,
    parameter int MAX_DELAY     = 64,
    parameter int DEFAULT_DELAY = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            din,
    input  logic                         load,
    input  logic [dly_w(MAX_DELAY)-1:0]  load_delay,
    output logic [DATA_W-1:0]            dout,
`ifdef LANE_DELAY_DIFF_OUT_EN
    output logic [DATA_W-1:0]            dout_n,
`endif
    output logic                         dout_valid
);
    localparam int PW = ptr_w(MAX_DELAY);
    localparam int DW = dly_w(MAX_DELAY);

    logic [DATA_W-1:0] mem [MAX_DELAY];
    logic [PW-1:0]     wp;
    logic [DW-1:0]     dly, cnt, cnt_nxt;
    ld_state_e         st, st_nxt;
    logic [DATA_W-1:0] rd;

    // d = MAX_DELAY aliases the write slot, which still holds the oldest sample
    assign rd = (dly == '0) ? din : mem[wp - dly[PW-1:0]];
    assign dout_valid = (st == LD_LOCKED);

    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        if (load) begin
            st_nxt  = LD_SETTLE;
            cnt_nxt = load_delay + DW'(1);
        end else if (st == LD_SETTLE) begin
            cnt_nxt = cnt - DW'(1);
            st_nxt  = (cnt == DW'(1)) ? LD_LOCKED : LD_SETTLE;
        end
    end

    always_ff @(posedge clk)
        mem[wp] <= din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp     <= '0;
            dly    <= DW'(DEFAULT_DELAY);
            cnt    <= DW'(DEFAULT_DELAY + 1);
            st     <= LD_RST_STATE;
            dout   <= '0;
`ifdef LANE_DELAY_DIFF_OUT_EN
            dout_n <= '1;
`endif
        end else begin
            wp     <= wp + PW'(1);
            if (load)
                dly <= load_delay;
            cnt    <= cnt_nxt;
            st     <= st_nxt;
            dout   <= (st_nxt == LD_LOCKED) ? rd : '0;
`ifdef LANE_DELAY_DIFF_OUT_EN
            dout_n <= (st_nxt == LD_LOCKED) ? ~rd : '1;
`endif
        end
    end
endmodule

// File: rtl/lane_delay_line.sv
// lane_delay_line: N_CH-lane programmable delay line with per-lane lock status.
// Define LANE_DELAY_DIFF_OUT_EN to add the complementary dout_n output.
module lane_delay_line
    import lane_delay_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DATA_W        = 1,
    parameter int MAX_DELAY     = 64,
    parameter int DEFAULT_DELAY = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CH*DATA_W-1:0]       din,
    output logic [N_CH*DATA_W-1:0]       dout,
`ifdef LANE_DELAY_DIFF_OUT_EN
    output logic [N_CH*DATA_W-1:0]       dout_n,
`endif
    output logic [N_CH-1:0]              dout_valid,
    output logic                         all_locked,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [ch_w(N_CH)-1:0]        cfg_ch,
    input  logic [dly_w(MAX_DELAY)-1:0]  cfg_delay,
    output logic                         cfg_err
);
    localparam int CW = ch_w(N_CH);
    localparam int DW = dly_w(MAX_DELAY);

    logic          cfg_ok, cfg_acc, ld_we;
    logic [CW-1:0] ld_ch;
    logic [DW-1:0] ld_delay;

    assign cfg_acc    = cfg_valid && cfg_ready;
    assign cfg_ok     = ({1'b0, cfg_ch} < (CW+1)'(N_CH)) && (cfg_delay <= DW'(MAX_DELAY));
    assign all_locked = &dout_valid;

    // requests are staged one edge so no cfg input reaches a lane combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready <= LD_RST_READY;
            cfg_err   <= LD_RST_ERR;
            ld_we     <= 1'b0;
            ld_ch     <= '0;
            ld_delay  <= '0;
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= cfg_acc && !cfg_ok;
            ld_we     <= cfg_acc && cfg_ok;
            if (cfg_acc) begin
                ld_ch    <= cfg_ch;
                ld_delay <= cfg_delay;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        lane_delay_ch #(
            .DATA_W(DATA_W),
            .MAX_DELAY(MAX_DELAY),
            .DEFAULT_DELAY(DEFAULT_DELAY)
        ) u_ch (
            .clk(clk),
            .rst_n(rst_n),
            .din(din[k*DATA_W +: DATA_W]),
            .load(ld_we && (ld_ch == CW'(k))),
            .load_delay(ld_delay),
            .dout(dout[k*DATA_W +: DATA_W]),
`ifdef LANE_DELAY_DIFF_OUT_EN
            .dout_n(dout_n[k*DATA_W +: DATA_W]),
`endif
            .dout_valid(dout_valid[k])
        );
    end
endmodule

// File: tb/tb_lane_delay_line.sv
// tb_lane_delay_line: directed + randomized checks of lane_delay_line against an edge-history model.
module tb_lane_delay_line;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din, dout, dout_valid;
    logic       all_locked, cfg_valid, cfg_ready, cfg_err;
    logic [1:0] cfg_ch;
    logic [6:0] cfg_delay;
`ifdef LANE_DELAY_DIFF_OUT_EN
    logic [3:0] dout_n;
`endif

    int         tests = 0, fails = 0;
    int         t;
    logic [3:0] hist [0:1023];
    int         e1 [4];
    int         dl [4];
    logic       m_ready;

    always #5 clk = ~clk;

    lane_delay_line #(.N_CH(4), .DATA_W(1), .MAX_DELAY(64), .DEFAULT_DELAY(0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .dout(dout),
`ifdef LANE_DELAY_DIFF_OUT_EN
        .dout_n(dout_n),
`endif
        .dout_valid(dout_valid),
        .all_locked(all_locked),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_delay(cfg_delay),
        .cfg_err(cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e1[k] = 0;
            dl[k] = 0;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_all_locked", 32'(all_locked), 32'h0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'h0);
        chk("rst_cfg_err", 32'(cfg_err), 32'h0);
`ifdef LANE_DELAY_DIFF_OUT_EN
        chk("rst_dout_n", 32'(dout_n), 32'hf);
`endif
    endtask

    // one clock edge: drive at negedge, then compare against the lane history rules
    task automatic cyc(input logic [3:0] d, input logic v, input logic [1:0] ch, input int dly);
        logic [3:0] ed, ev;
        logic       acc, bad;
        @(negedge clk);
        din = d;
        cfg_valid = v;
        cfg_ch = ch;
        cfg_delay = 7'(dly);
        @(posedge clk);
        t++;
        hist[t] = d;
        acc = v && m_ready;
        bad = dly > 64;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ev[k] = (t >= e1[k] + dl[k] + 1);
            ed[k] = ev[k] ? hist[t - dl[k]][k] : 1'b0;
        end
        #1;
        chk("dout", 32'(dout), 32'(ed));
        chk("dout_valid", 32'(dout_valid), 32'(ev));
        chk("all_locked", 32'(all_locked), 32'(&ev));
        chk("cfg_ready", 32'(cfg_ready), 32'h1);
        chk("cfg_err", 32'(cfg_err), 32'(acc && bad));
`ifdef LANE_DELAY_DIFF_OUT_EN
        chk("dout_n", 32'(dout_n), 32'(~ed));
`endif
        if (acc && !bad) begin
            e1[ch] = t + 1;
            dl[ch] = dly;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        din = '0;
        cfg_valid = 1'b0;
        cfg_ch = '0;
        cfg_delay = '0;
        model_reset();
        #2;
        chk_reset_outputs();
        @(posedge clk);
        #2 rst_n = 1'b1;
        // counting pattern, default delay 0
        for (int i = 0; i < 20; i++) cyc(4'(i), 1'b0, 2'd0, 0);
        // lane 2 to delay 10 while others run
        cyc(4'($urandom), 1'b1, 2'd2, 10);
        for (int i = 0; i < 30; i++) cyc(4'($urandom), 1'b0, 2'd0, 0);
        // lane 0 to the maximum delay, then a single pulse through the wrap
        cyc(4'h0, 1'b1, 2'd0, 64);
        for (int i = 0; i < 70; i++) cyc(4'h0, 1'b0, 2'd0, 0);
        cyc(4'h1, 1'b0, 2'd0, 0);
        for (int i = 0; i < 70; i++) cyc(4'h0, 1'b0, 2'd0, 0);
        // out-of-range delays are rejected
        cyc(4'($urandom), 1'b1, 2'd1, 65);
        cyc(4'($urandom), 1'b1, 2'd3, 127);
        for (int i = 0; i < 4; i++) cyc(4'($urandom), 1'b0, 2'd0, 0);
        // back-to-back requests to lane 1
        cyc(4'($urandom), 1'b1, 2'd1, 20);
        cyc(4'($urandom), 1'b1, 2'd1, 3);
        for (int i = 0; i < 10; i++) cyc(4'($urandom), 1'b0, 2'd0, 0);
        // random traffic including invalid delays
        for (int i = 0; i < 80; i++)
            cyc(4'($urandom), $urandom_range(0, 3) == 0, 2'($urandom), int'($urandom_range(0, 70)));
        for (int i = 0; i < 10; i++) cyc(4'($urandom), 1'b0, 2'd0, 0);
        // reset while lane 3 settles
        cyc(4'($urandom), 1'b1, 2'd3, 30);
        for (int i = 0; i < 5; i++) cyc(4'($urandom), 1'b0, 2'd0, 0);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs();
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc(4'($urandom), 1'b0, 2'd0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
